flit_depacketizer: RTL and testbench

Parametrised receive-side depacketizer. It accepts typed flits from the NoC router egress port over a valid/ready handshake and checks the head/body/tail framing. It serialises each flit payload into DATA_W-bit words for the local core, with per-packet header sideband and an end-of-packet marker. It is the successor to the fixed 48-to-16-bit depacketizer: it adds backpressure, multi-word flits, partial tail flits, single-flit packets and framing-error reporting.

---
 rtl/depkt_pkg.sv | 28 ++
 rtl/flit_word_shifter.sv | 53 +++++
 rtl/flit_depacketizer.sv | 151 +++++++++++++++
 tb/tb_flit_depacketizer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/depkt_pkg.sv
// Shared types, error codes and flit field helpers for the flit depacketizer.
package depkt_pkg;

  typedef enum logic [1:0] {
    FT_HEAD_TAIL = 2'b00,
    FT_HEAD      = 2'b01,
    FT_BODY      = 2'b10,
    FT_TAIL      = 2'b11
  } flit_type_e;

  localparam logic [1:0] ERR_NONE        = 2'b00;
  localparam logic [1:0] ERR_ORPHAN      = 2'b01;
  localparam logic [1:0] ERR_HEAD_IN_PKT = 2'b10;
  localparam logic [1:0] ERR_BAD_CNT     = 2'b11;

  function automatic int pay_w(int dw, int words);
    return dw * words;
  endfunction

  function automatic int hdr_w(int fw, int dw, int words);
    return fw - 2 - dw * words;
  endfunction

  function automatic int cnt_w(int words);
    return $clog2(words) + 1;
  endfunction

endpackage

// File: rtl/flit_word_shifter.sv
// Holds one flit payload and emits its valid words in order
// over a valid/ready handshake.
module flit_word_shifter #(
  parameter int DATA_W = 16,
  parameter int WORDS  = 2,
  parameter int CNT_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [WORDS*DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]        load_cnt,
  input  logic                    load_last,
  output logic                    free,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WORDS*DATA_W-1:0] data_q;
  logic [CNT_W-1:0]        idx_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    last_q;
  logic                    valid_q;
  logic                    at_end;

  assign at_end    = (idx_q == cnt_q - 1'b1);
  assign free      = !valid_q || (out_ready && at_end);
  assign out_valid = valid_q;
  assign out_data  = data_q[idx_q*DATA_W +: DATA_W];
  assign out_last  = valid_q && last_q && at_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= load_data;
      idx_q   <= '0;
      cnt_q   <= load_cnt;
      last_q  <= load_last;
      valid_q <= 1'b1;
    end else if (valid_q && out_ready) begin
      if (at_end) valid_q <= 1'b0;
      else        idx_q   <= idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/flit_depacketizer.sv
// Receive-side flit depacketizer: framing check, header latch, word serialiser.
// Optional DEPKT_STATS_EN adds packet and error counters.
module flit_depacketizer
  import depkt_pkg::*;
#(
  parameter int FLIT_W = 48,
  parameter int DATA_W = 16,
  parameter int WORDS  = 2,
  localparam int HDR_W = hdr_w(FLIT_W, DATA_W, WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [HDR_W-1:0]  out_hdr,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_pulse,
  output logic [1:0]        err_code
`ifdef DEPKT_STATS_EN
  ,
  output logic [31:0]       pkt_count,
  output logic [15:0]       err_count
`endif
);

  localparam int PW = pay_w(DATA_W, WORDS);
  localparam int CW = cnt_w(WORDS);
  localparam logic [CW-1:0] MAX_CNT = CW'(WORDS);

  if (HDR_W < CW) begin : g_cfg_err
    $error("flit_depacketizer: header too narrow for count");
  end

  typedef enum logic {IDLE, IN_PKT} state_e;

  state_e           state_q, state_d;
  flit_type_e       ftype;
  logic [HDR_W-1:0] hdr_f;
  logic [CW-1:0]    raw_cnt;
  logic [CW-1:0]    load_cnt;
  logic             has_cnt;
  logic             bad_cnt;
  logic             accept;
  logic             drop;
  logic             hdr_ld;
  logic [1:0]       err_d;
  logic [HDR_W-1:0] hdr_q;

  assign ftype   = flit_type_e'(in_flit[FLIT_W-1 -: 2]);
  assign hdr_f   = in_flit[PW +: HDR_W];
  assign raw_cnt = hdr_f[CW-1:0];
  assign has_cnt = (ftype == FT_HEAD_TAIL) || (ftype == FT_TAIL);
  assign bad_cnt = has_cnt && (raw_cnt == '0 || raw_cnt > MAX_CNT);
  assign load_cnt = (has_cnt && !bad_cnt) ? raw_cnt : MAX_CNT;
  assign accept  = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    drop    = 1'b0;
    hdr_ld  = 1'b0;
    err_d   = ERR_NONE;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          unique case (ftype)
            FT_HEAD: begin
              state_d = IN_PKT;
              hdr_ld  = 1'b1;
            end
            FT_HEAD_TAIL: hdr_ld = 1'b1;
            default: begin
              drop  = 1'b1;
              err_d = ERR_ORPHAN;
            end
          endcase
        end
        IN_PKT: begin
          unique case (ftype)
            FT_BODY: state_d = IN_PKT;
            FT_TAIL: state_d = IDLE;
            FT_HEAD: begin
              hdr_ld = 1'b1;
              err_d  = ERR_HEAD_IN_PKT;
            end
            FT_HEAD_TAIL: begin
              state_d = IDLE;
              hdr_ld  = 1'b1;
              err_d   = ERR_HEAD_IN_PKT;
            end
          endcase
        end
      endcase
      // framing errors take priority over a bad count
      if (!drop && err_d == ERR_NONE && bad_cnt)
        err_d = ERR_BAD_CNT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      hdr_q     <= '0;
      err_pulse <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      err_pulse <= (err_d != ERR_NONE);
      if (hdr_ld) hdr_q <= hdr_f;
      if (err_d != ERR_NONE) err_code <= err_d;
    end
  end

  assign out_hdr = hdr_q;

  flit_word_shifter #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS),
    .CNT_W  (CW)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (accept && !drop),
    .load_data (in_flit[PW-1:0]),
    .load_cnt  (load_cnt),
    .load_last (has_cnt),
    .free      (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

`ifdef DEPKT_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (out_valid && out_ready && out_last)
        pkt_count <= pkt_count + 1'b1;
      if (err_pulse && err_count != 16'hFFFF)
        err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_flit_depacketizer.sv
// Self-checking bench for flit_depacketizer against a queue-based
// packet model; directed test-plan steps followed by random traffic.
module tb_flit_depacketizer;

  localparam int FLIT_W = 48;
  localparam int DATA_W = 16;
  localparam int WORDS  = 2;
  localparam int HDR_W  = FLIT_W - 2 - WORDS * DATA_W;
  localparam int CW     = $clog2(WORDS) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [FLIT_W-1:0] in_flit;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic [HDR_W-1:0]  out_hdr;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  logic              err_pulse;
  logic [1:0]        err_code;
`ifdef DEPKT_STATS_EN
  logic [31:0]       pkt_count;
  logic [15:0]       err_count;
`endif

  always #5 clk = ~clk;

  flit_depacketizer #(
    .FLIT_W (FLIT_W),
    .DATA_W (DATA_W),
    .WORDS  (WORDS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_hdr   (out_hdr),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_pulse (err_pulse),
    .err_code  (err_code)
`ifdef DEPKT_STATS_EN
    ,
    .pkt_count (pkt_count),
    .err_count (err_count)
`endif
  );

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [HDR_W-1:0]  h;
    logic              l;
  } word_t;

  word_t            q[$];
  bit               in_pkt;
  logic [HDR_W-1:0] cur_hdr;
  logic [1:0]       pend;
  logic [1:0]       exp_code;
  bit               exp_pulse;
  int               pkt_m;
  int               errc_m;
  int               checks = 0;
  int               errors = 0;
  int               stall_pct = 0;
  bit               accepted;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(logic [1:0] t,
      logic [HDR_W-1:0] h, logic [WORDS*DATA_W-1:0] p);
    return {t, h, p};
  endfunction

  function automatic void model_reset();
    q.delete();
    in_pkt    = 0;
    cur_hdr   = '0;
    pend      = 2'b00;
    exp_code  = 2'b00;
    exp_pulse = 0;
    pkt_m     = 0;
    errc_m    = 0;
  endfunction

  function automatic void model_accept(logic [FLIT_W-1:0] f);
    logic [1:0]              t;
    logic [HDR_W-1:0]        h;
    logic [WORDS*DATA_W-1:0] p;
    int                      n;
    bit                      lst;
    bit                      drop;
    logic [1:0]              e;
    word_t                   w;
    t    = f[FLIT_W-1 -: 2];
    h    = f[WORDS*DATA_W +: HDR_W];
    p    = f[WORDS*DATA_W-1:0];
    n    = int'(h[CW-1:0]);
    lst  = 0;
    drop = 0;
    e    = 2'b00;
    case (t)
      2'b00: begin
        if (in_pkt) e = 2'b10;
        in_pkt = 0; cur_hdr = h; lst = 1;
      end
      2'b01: begin
        if (in_pkt) e = 2'b10;
        in_pkt = 1; cur_hdr = h; n = WORDS;
      end
      2'b10: begin
        if (!in_pkt) begin e = 2'b01; drop = 1; end
        n = WORDS;
      end
      default: begin
        if (!in_pkt) begin e = 2'b01; drop = 1; end
        else in_pkt = 0;
        lst = 1;
      end
    endcase
    if (!drop && (n < 1 || n > WORDS)) begin
      n = WORDS;
      if (e == 2'b00) e = 2'b11;
    end
    if (!drop)
      for (int i = 0; i < n; i++) begin
        w.d = p[i*DATA_W +: DATA_W];
        w.h = cur_hdr;
        w.l = lst && (i == n - 1);
        q.push_back(w);
      end
    pend = e;
  endfunction

  task automatic step();
    out_ready = ($urandom_range(99) >= stall_pct);
    @(negedge clk);
    exp_pulse = (pend != 2'b00);
    if (exp_pulse) exp_code = pend;
    pend = 2'b00;
    chk("err_pulse", err_pulse, exp_pulse);
    chk("err_code", err_code, exp_code);
`ifdef DEPKT_STATS_EN
    chk("pkt_count", pkt_count, pkt_m);
    chk("err_count", err_count, errc_m);
`endif
    if (exp_pulse && errc_m < 65535) errc_m++;
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready,
        (q.size() == 0) || (out_ready && q.size() == 1));
    if (q.size() != 0 && out_valid) begin
      chk("out_data", out_data, q[0].d);
      chk("out_hdr", out_hdr, q[0].h);
      chk("out_last", out_last, q[0].l);
      if (out_ready) begin
        if (q[0].l) pkt_m++;
        void'(q.pop_front());
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) model_accept(in_flit);
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [FLIT_W-1:0] f);
    in_flit  = f;
    in_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 100 && !accepted; i++) step();
    chk("accept_timeout", accepted, 1'b1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 200 && q.size() != 0; i++) step();
    step();
    step();
    chk("drain_timeout", q.size() == 0, 1'b1);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    model_reset();
    #3;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_hdr", out_hdr, '0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_err_pulse", err_pulse, 1'b0);
    chk("rst_err_code", err_code, 2'b00);
`ifdef DEPKT_STATS_EN
    chk("rst_pkt_count", pkt_count, '0);
    chk("rst_err_count", err_count, '0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    in_flit   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    do_reset();

    send(mk(2'b01, 14'h0A5, 32'h2222_1111));
    send(mk(2'b10, 14'h000, 32'h4444_3333));
    send(mk(2'b11, 14'h001, 32'hABCD_5555));
    drain();

    send(mk(2'b00, 14'h002, 32'hBEEF_CAFE));
    drain();

    send(mk(2'b10, 14'h000, 32'h7777_6666));
    drain();
    send(mk(2'b01, 14'h0C0, 32'h8888_9999));
    send(mk(2'b11, 14'h002, 32'hAAAA_BBBB));
    drain();

    send(mk(2'b01, 14'h0D0, 32'h1234_5678));
    send(mk(2'b10, 14'h000, 32'h9ABC_DEF0));
    send(mk(2'b01, 14'h011, 32'h0F0F_F0F0));
    send(mk(2'b11, 14'h001, 32'h0000_5A5A));
    drain();

    do_reset();
    send(mk(2'b01, 14'h033, 32'h2002_1001));
    send(mk(2'b11, 14'h000, 32'h4004_3003));
    drain();
`ifdef DEPKT_STATS_EN
    chk("stats_err_count", err_count, 16'd1);
    chk("stats_pkt_count", pkt_count, 32'd1);
`endif

    stall_pct = 50;
    send(mk(2'b01, 14'h044, $urandom));
    send(mk(2'b10, 14'h000, $urandom));
    send(mk(2'b10, 14'h000, $urandom));
    send(mk(2'b11, 14'h002, $urandom));
    drain();

    send(mk(2'b01, 14'h055, $urandom));
    send(mk(2'b10, 14'h000, $urandom));
    in_valid = 1'b0;
    step();
    do_reset();
    send(mk(2'b11, 14'h002, 32'h1111_2222));
    drain();

    for (int k = 0; k < 400; k++) begin
      stall_pct = (k % 3 == 0) ? 0 : 35;
      send(mk(2'($urandom_range(3)), 14'($urandom), $urandom));
      if ($urandom_range(9) == 0) drain();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
